digits_display_dec: RTL and testbench

- Parametrised successor to the fixed 7-digit baud/ASCII display.
- Takes an arbitrary binary value on a load strobe and converts it to NUM_DIGITS decimal digits (sequential double-dabble) or hex digits (direct slicing).
- Applies optional leading-zero blanking and drives per-digit 7-segment outputs.
- Sits between the UART control logic (baud select, TX/RX data) and the board seven-segment bank; baud rates are shown as their numeric value rather than from per-rate lookup tables.

---
 rtl/digits_display_dec_pkg.sv | 53 +++++
 rtl/digits_display_dec_seg7_decode.sv | 17 +
 rtl/digits_display_dec.sv | 158 +++++++++++++++
 tb/tb_digits_display_dec.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digits_display_dec_pkg.sv
// Shared definitions for the digit display converter: radix codes, active-low
// segment glyphs ordered {g,f,e,d,c,b,a}, and FSM state encodings.
package digits_display_dec_pkg;

  localparam logic RADIX_DEC = 1'b0;
  localparam logic RADIX_HEX = 1'b1;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/digits_display_dec_seg7_decode.sv
// One digit of 7-segment decode: nibble plus enable to active-low segment lines.
module seg7_decode
  import digits_display_dec_pkg::*;
#(
  parameter int SEG_W = 7
) (
  input  logic [3:0]       nibble,
  input  logic             en,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = {SEG_W{1'b1}};
    if (en) seg[6:0] = glyph(nibble);
  end

endmodule

// File: rtl/digits_display_dec.sv
// Binary-to-digit display converter: sequential double-dabble for decimal,
// direct nibble slicing for hex, leading-zero blanking, per-digit 7-seg drive.
module digits_display_dec
  import digits_display_dec_pkg::*;
#(
  parameter int NUM_DIGITS = 7,
  parameter int VALUE_W    = 20,
  parameter int SEG_W      = 7
) (
  input  logic                        src_clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [VALUE_W-1:0]          value,
  input  logic                        radix,
  input  logic                        blank_lz,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [4*NUM_DIGITS-1:0]     digits,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic [SEG_W*NUM_DIGITS-1:0] Display
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int SW    = DW + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic [DW-1:0]           digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  // Operand/working registers carry no reset; they are always loaded before use.
  logic [SW-1:0]           shift_q, shift_d;
  logic                    radix_q, radix_d;
  logic                    blank_q, blank_d;
  logic                    ovf_acc_q, ovf_acc_d;

  logic [DW-1:0]           bcd_adj;
  logic [SW-1:0]           bin_ext;
  logic [DW-1:0]           res_dig;
  logic                    res_ovf;
  logic [NUM_DIGITS-1:0]   en_new;
  logic                    lit;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shift_q[VALUE_W + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = shift_q[VALUE_W + 4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = shift_q[VALUE_W + 4*i +: 4];
    end
  end

  always_comb begin
    bin_ext = {{DW{1'b0}}, shift_q[VALUE_W-1:0]};
    if (radix_q == RADIX_HEX) begin
      res_dig = bin_ext[DW-1:0];
      res_ovf = |(bin_ext >> DW);
    end else begin
      res_dig = shift_q[SW-1:VALUE_W];
      res_ovf = ovf_acc_q;
    end
  end

  // Scan from the top digit down; once a nonzero digit is seen, all below are lit.
  always_comb begin
    lit    = 1'b0;
    en_new = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lit       = lit | (res_dig[4*i +: 4] != 4'd0) | (i == 0) | ~blank_q;
      en_new[i] = lit;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    digits_d   = digits_q;
    digit_en_d = digit_en_q;
    shift_d    = shift_q;
    radix_d    = radix_q;
    blank_d    = blank_q;
    ovf_acc_d  = ovf_acc_q;
    case (state_q)
      ST_IDLE: begin
        // The done cycle still belongs to the previous conversion, so load waits.
        if (load && !done_q) begin
          shift_d   = {{DW{1'b0}}, value};
          radix_d   = radix;
          blank_d   = blank_lz;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(VALUE_W);
          state_d   = (radix == RADIX_DEC) ? ST_CONVERT : ST_COMMIT;
        end
      end
      ST_CONVERT: begin
        shift_d   = {bcd_adj, shift_q[VALUE_W-1:0]} << 1;
        ovf_acc_d = ovf_acc_q | bcd_adj[DW-1];
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d   = res_dig;
        digit_en_d = en_new;
        overflow_d = res_ovf;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
      digit_en_q <= NUM_DIGITS'(1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
      digit_en_q <= digit_en_d;
    end
  end

  always_ff @(posedge src_clk) begin
    shift_q   <= shift_d;
    radix_q   <= radix_d;
    blank_q   <= blank_d;
    ovf_acc_q <= ovf_acc_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digits   = digits_q;
  assign digit_en = digit_en_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    seg7_decode #(.SEG_W(SEG_W)) u_seg (
      .nibble (digits_q[4*g +: 4]),
      .en     (digit_en_q[g]),
      .seg    (Display[SEG_W*g +: SEG_W])
    );
  end

endmodule

// File: tb/tb_digits_display_dec.sv
// Self-checking bench for digits_display_dec: directed cases, randomized loads
// against an arithmetic reference, overflow on a narrow instance, protocol and reset.
module tb_digits_display_dec;

  localparam int ND   = 7;
  localparam int VW   = 20;
  localparam int SGW  = 7;
  localparam int ND_S = 3;
  localparam int VW_S = 10;

  logic src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  logic rst_n;
  logic load, radix, blank_lz;
  logic [VW-1:0] value;
  logic busy, done, overflow;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_en;
  logic [SGW*ND-1:0] display;

  logic load_s, radix_s, blank_s;
  logic [VW_S-1:0] value_s;
  logic busy_s, done_s, overflow_s;
  logic [4*ND_S-1:0] digits_s;
  logic [ND_S-1:0] digit_en_s;
  logic [SGW*ND_S-1:0] display_s;

  int total = 0;
  int bad = 0;

  digits_display_dec #(.NUM_DIGITS(ND), .VALUE_W(VW), .SEG_W(SGW)) dut (
    .src_clk(src_clk), .rst_n(rst_n), .load(load), .value(value), .radix(radix),
    .blank_lz(blank_lz), .busy(busy), .done(done), .overflow(overflow),
    .digits(digits), .digit_en(digit_en), .Display(display)
  );

  digits_display_dec #(.NUM_DIGITS(ND_S), .VALUE_W(VW_S), .SEG_W(SGW)) dut_s (
    .src_clk(src_clk), .rst_n(rst_n), .load(load_s), .value(value_s), .radix(radix_s),
    .blank_lz(blank_s), .busy(busy_s), .done(done_s), .overflow(overflow_s),
    .digits(digits_s), .digit_en(digit_en_s), .Display(display_s)
  );

  // Reference: repeated division by the radix, blanking above the highest nonzero digit.
  function automatic void ref_model(input logic [31:0] v, input bit hex, input bit blz,
                                    input int nd, output logic [31:0] dig,
                                    output logic [7:0] en, output bit ovf);
    longint unsigned base;
    longint unsigned x;
    int top;
    base = hex ? 16 : 10;
    x = longint'(v);
    top = 0;
    dig = '0;
    en = '0;
    for (int i = 0; i < nd; i++) begin
      dig[4*i +: 4] = 4'(x % base);
      x = x / base;
    end
    ovf = (x != 0);
    for (int i = 0; i < nd; i++) if (dig[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < nd; i++) en[i] = !blz || (i <= top);
  endfunction

  // Active-high textbook glyphs, inverted for the active-low bank.
  function automatic logic [6:0] seg_ref(input logic [3:0] n, input bit e);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return e ? ~on : 7'h7F;
  endfunction

  task automatic run_conv(input logic [VW-1:0] v, input bit r, input bit b, output int lat);
    @(posedge src_clk);
    @(negedge src_clk);
    value = v; radix = r; blank_lz = b; load = 1'b1;
    @(posedge src_clk);
    #1 load = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge src_clk);
      #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic run_small(input logic [VW_S-1:0] v, input bit r, input bit b, output int lat);
    @(posedge src_clk);
    @(negedge src_clk);
    value_s = v; radix_s = r; blank_s = b; load_s = 1'b1;
    @(posedge src_clk);
    #1 load_s = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge src_clk);
      #1;
      if (done_s) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    logic [SGW*ND-1:0] exp_disp;
    exp_disp = {{(ND-1){7'h7F}}, 7'h40};
    rst_n = 1'b0;
    repeat (3) @(posedge src_clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (digits !== '0) begin bad++; $display("FAIL reset_digits got=%h want=0", digits); end
    total++; if (digit_en !== 7'b0000001) begin bad++; $display("FAIL reset_en got=%b want=0000001", digit_en); end
    total++; if (display !== exp_disp) begin bad++; $display("FAIL reset_display got=%h want=%h", display, exp_disp); end
    total++; if (digit_en_s !== 3'b001) begin bad++; $display("FAIL reset_en_small got=%b want=001", digit_en_s); end
    @(negedge src_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [VW-1:0] tv [5];
    bit            tr [5];
    bit            tb [5];
    int            tl [5];
    logic [27:0]   td [5];
    logic [6:0]    te [5];
    int lat;
    logic [SGW*ND-1:0] exp_disp;
    tv = '{20'd115200, 20'd9600, 20'd9600, 20'h00041, 20'd0};
    tr = '{0, 0, 0, 1, 0};
    tb = '{1, 1, 0, 1, 1};
    tl = '{21, 21, 21, 1, 21};
    td = '{28'h0115200, 28'h0009600, 28'h0009600, 28'h0000041, 28'h0000000};
    te = '{7'b0111111, 7'b0001111, 7'b1111111, 7'b0000011, 7'b0000001};
    for (int k = 0; k < 5; k++) begin
      run_conv(tv[k], tr[k], tb[k], lat);
      total++; if (lat !== tl[k]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, tl[k]); end
      total++; if (digits !== td[k]) begin bad++; $display("FAIL dir%0d_digits got=%h want=%h", k, digits, td[k]); end
      total++; if (digit_en !== te[k]) begin bad++; $display("FAIL dir%0d_en got=%b want=%b", k, digit_en, te[k]); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL dir%0d_ovf got=%b want=0", k, overflow); end
      for (int i = 0; i < ND; i++) exp_disp[7*i +: 7] = seg_ref(td[k][4*i +: 4], te[k][i]);
      total++; if (display !== exp_disp) begin bad++; $display("FAIL dir%0d_display got=%h want=%h", k, display, exp_disp); end
      if (k == 2) begin
        total++;
        if (display[48:28] !== {3{7'h40}}) begin bad++; $display("FAIL dir_zero_glyphs got=%h want=%h", display[48:28], {3{7'h40}}); end
      end
      if (k == 4) begin
        total++;
        if (display[6:0] !== 7'h40) begin bad++; $display("FAIL dir_zero_seg0 got=%h want=40", display[6:0]); end
      end
    end
    @(posedge src_clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", done); end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    bit r, b, eo;
    int lat;
    logic [31:0] ed;
    logic [7:0] ee;
    logic [SGW*ND-1:0] exp_disp;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: v = VW'($urandom);
        1: v = VW'($urandom_range(0, 999));
        2: v = VW'($urandom_range(0, 15));
        default: v = '0;
      endcase
      r = 1'($urandom);
      b = 1'($urandom);
      ref_model(32'(v), r, b, ND, ed, ee, eo);
      run_conv(v, r, b, lat);
      total++; if (lat !== (r ? 1 : VW + 1)) begin bad++; $display("FAIL rnd_latency v=%h r=%0d got=%0d want=%0d", v, r, lat, r ? 1 : VW + 1); end
      total++; if (digits !== ed[27:0]) begin bad++; $display("FAIL rnd_digits v=%h r=%0d got=%h want=%h", v, r, digits, ed[27:0]); end
      total++; if (digit_en !== ee[6:0]) begin bad++; $display("FAIL rnd_en v=%h b=%0d got=%b want=%b", v, b, digit_en, ee[6:0]); end
      total++; if (overflow !== eo) begin bad++; $display("FAIL rnd_ovf v=%h got=%b want=%b", v, overflow, eo); end
      for (int i = 0; i < ND; i++) exp_disp[7*i +: 7] = seg_ref(ed[4*i +: 4], ee[i]);
      total++; if (display !== exp_disp) begin bad++; $display("FAIL rnd_display v=%h got=%h want=%h", v, display, exp_disp); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy_at_done got=%b want=0", busy); end
    end
  endtask

  task automatic test_overflow();
    logic [VW_S-1:0] v;
    bit r, b, eo;
    int lat;
    logic [31:0] ed;
    logic [7:0] ee;
    run_small(10'd1000, 1'b0, 1'b1, lat);
    total++; if (lat !== VW_S + 1) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", lat, VW_S + 1); end
    total++; if (overflow_s !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_s); end
    total++; if (digits_s !== 12'h000) begin bad++; $display("FAIL ovf_digits got=%h want=000", digits_s); end
    for (int k = 0; k < 12; k++) begin
      v = (k % 3 == 0) ? VW_S'($urandom_range(0, 999)) : VW_S'($urandom_range(900, 1023));
      r = (k % 4 == 3);
      b = 1'($urandom);
      ref_model(32'(v), r, b, ND_S, ed, ee, eo);
      run_small(v, r, b, lat);
      total++; if (digits_s !== ed[11:0]) begin bad++; $display("FAIL small_digits v=%0d r=%0d got=%h want=%h", v, r, digits_s, ed[11:0]); end
      total++; if (digit_en_s !== ee[2:0]) begin bad++; $display("FAIL small_en v=%0d got=%b want=%b", v, digit_en_s, ee[2:0]); end
      total++; if (overflow_s !== eo) begin bad++; $display("FAIL small_ovf v=%0d got=%b want=%b", v, overflow_s, eo); end
    end
  endtask

  task automatic test_busy_load();
    int lat;
    int dones;
    @(posedge src_clk);
    @(negedge src_clk);
    value = 20'd115200; radix = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(posedge src_clk);
    #1 load = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_load got=%b want=1", busy); end
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge src_clk);
      #1;
      if (n == 3) begin value = 20'd9600; radix = 1'b1; blank_lz = 1'b0; load = 1'b1; end
      if (n == 4) load = 1'b0;
      if (done) begin lat = n; break; end
    end
    total++; if (lat !== VW + 1) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", lat, VW + 1); end
    total++; if (digits !== 28'h0115200) begin bad++; $display("FAIL busy_digits got=%h want=0115200", digits); end
    total++; if (digit_en !== 7'b0111111) begin bad++; $display("FAIL busy_en got=%b want=0111111", digit_en); end
    // A load presented during the done cycle must not start a conversion.
    value = 20'd7; radix = 1'b1; blank_lz = 1'b0; load = 1'b1;
    @(posedge src_clk);
    #1 load = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_cycle_load_busy got=%b want=0", busy); end
    dones = 0;
    repeat (4) begin @(posedge src_clk); #1; if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL done_cycle_load_done got=%0d want=0", dones); end
    total++; if (digits !== 28'h0115200) begin bad++; $display("FAIL done_cycle_load_digits got=%h want=0115200", digits); end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [SGW*ND-1:0] exp_disp;
    exp_disp = {{(ND-1){7'h7F}}, 7'h40};
    @(posedge src_clk);
    @(negedge src_clk);
    value = 20'd98765; radix = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(posedge src_clk);
    #1 load = 1'b0;
    repeat (5) @(posedge src_clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (digit_en !== 7'b0000001) begin bad++; $display("FAIL midrst_en got=%b want=0000001", digit_en); end
    total++; if (digits !== '0) begin bad++; $display("FAIL midrst_digits got=%h want=0", digits); end
    total++; if (display !== exp_disp) begin bad++; $display("FAIL midrst_display got=%h want=%h", display, exp_disp); end
    repeat (2) @(posedge src_clk);
    @(negedge src_clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin @(posedge src_clk); #1; if (done || busy) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0; radix = 1'b0; blank_lz = 1'b0; value = '0;
    load_s = 1'b0; radix_s = 1'b0; blank_s = 1'b0; value_s = '0;
    test_reset();
    test_directed();
    test_random();
    test_overflow();
    test_busy_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
